// File: rtl/rob_pkg.sv
// ============================================================================
//  Package    : rv32i_types
//  Description: Shared types and default constants for the Tomasulo RV32I
//               core. Holds the reorder-buffer entry record and the default
//               reorder-buffer depth.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

  localparam int c_DATA_WIDTH = 32;  // XLEN
  localparam int c_ADDR_WIDTH = 5;   // architectural register index width
  localparam int c_ROB_LENGTH = 8;   // default reorder-buffer depth

  // One in-flight instruction. data/rd_addr widths follow the RV32I core.
  typedef struct packed {
    logic                    valid;
    logic                    ready;
    logic                    mispredict;
    logic [c_ADDR_WIDTH-1:0] rd_addr;
    logic [c_DATA_WIDTH-1:0] data;
  } rob_entry_t;

endpackage

`default_nettype wire

// File: rtl/rob_if.sv
// ============================================================================
//  Interface  : rob_if
//  Description: Bundles every reorder-buffer signal except clock and reset:
//               decode allocation, CDB writeback, dispatch operand reads,
//               register-file commit and occupancy.
//  Modports   : master - decode / CDB / dispatch / register-file side
//               slave  - the reorder buffer itself
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rob_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ROB_LENGTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int ROB_WIDTH  = $clog2(ROB_LENGTH)
);

  // allocation
  logic                  alloc_valid;
  logic [ADDR_WIDTH-1:0] alloc_rd_addr;
  logic                  alloc_ready;
  logic [ROB_WIDTH-1:0]  alloc_rob_entry;
  // common data bus
  logic                  cdb_valid;
  logic [ROB_WIDTH-1:0]  cdb_rob_entry;
  logic [DATA_WIDTH-1:0] cdb_data;
  logic                  cdb_mispredict;
  // operand reads
  logic [ROB_WIDTH-1:0]  rs1_rob_entry;
  logic [ROB_WIDTH-1:0]  rs2_rob_entry;
  logic                  rs1_ready;
  logic                  rs2_ready;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  // commit
  logic                  regf_we;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ROB_WIDTH-1:0]  commit_rob_entry;
  logic                  br_flush;
  logic [ROB_WIDTH:0]    count;

  modport master (
    output alloc_valid, alloc_rd_addr, cdb_valid, cdb_rob_entry, cdb_data,
           cdb_mispredict, rs1_rob_entry, rs2_rob_entry,
    input  alloc_ready, alloc_rob_entry, rs1_ready, rs2_ready, rs1_data,
           rs2_data, regf_we, rd_addr, rd_data, commit_rob_entry, br_flush,
           count
  );

  modport slave (
    input  alloc_valid, alloc_rd_addr, cdb_valid, cdb_rob_entry, cdb_data,
           cdb_mispredict, rs1_rob_entry, rs2_rob_entry,
    output alloc_ready, alloc_rob_entry, rs1_ready, rs2_ready, rs1_data,
           rs2_data, regf_we, rd_addr, rd_data, commit_rob_entry, br_flush,
           count
  );

endinterface

`default_nettype wire

// File: rtl/rob.sv
// ============================================================================
//  Module     : rob
//  Description: Reorder buffer. Circular buffer of in-flight instructions:
//               allocates tags at decode, captures CDB results, retires in
//               program order into the register file and flushes everything
//               when a mispredicted branch/jump commits.
//  Ports      : clk  - clock
//               rst  - asynchronous reset, active low
//               bus  - rob_if.slave (allocation, CDB, operand reads, commit,
//                      count)
//  Config     : ROB_CDB_BYPASS_EN - when defined, operand reads see a
//               same-cycle CDB broadcast combinationally.
//  Note       : DATA_WIDTH / ADDR_WIDTH must match rv32i_types::rob_entry_t.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob
  import rv32i_types::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int ROB_LENGTH = c_ROB_LENGTH,
  parameter int ADDR_WIDTH = c_ADDR_WIDTH,
  parameter int ROB_WIDTH  = $clog2(ROB_LENGTH)
) (
  input  logic    clk,
  input  logic    rst,
  rob_if.slave    bus
);

  localparam logic [ROB_WIDTH:0] c_PTR_ONE = {{ROB_WIDTH{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit above the index.
  logic [ROB_WIDTH:0] r_head;
  logic [ROB_WIDTH:0] r_tail;
  rob_entry_t         r_entries [ROB_LENGTH];

  logic [ROB_WIDTH-1:0] w_head_idx;
  logic [ROB_WIDTH-1:0] w_tail_idx;
  logic                 w_full;
  logic                 w_commit;
  logic                 w_flush;
  logic                 w_alloc_fire;
  rob_entry_t           w_head_e;
  rob_entry_t           w_rs1_e;
  rob_entry_t           w_rs2_e;

  assign w_head_idx = r_head[ROB_WIDTH-1:0];
  assign w_tail_idx = r_tail[ROB_WIDTH-1:0];
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[ROB_WIDTH] != r_tail[ROB_WIDTH]);

  assign w_head_e     = r_entries[w_head_idx];
  assign w_commit     = w_head_e.valid && w_head_e.ready;
  assign w_flush      = w_commit && w_head_e.mispredict;
  // Fullness is taken from registered pointers only, so a slot freed by a
  // commit in this cycle is not reusable until the next one.
  assign w_alloc_fire = bus.alloc_valid && !w_full && !w_flush;

  // allocation / commit / occupancy
  assign bus.alloc_ready      = !w_full && !w_flush;
  assign bus.alloc_rob_entry  = w_tail_idx;
  assign bus.regf_we          = w_commit;
  assign bus.rd_addr          = w_head_e.rd_addr;
  assign bus.rd_data          = w_head_e.data;
  assign bus.commit_rob_entry = w_head_idx;
  assign bus.br_flush         = w_flush;
  assign bus.count            = r_tail - r_head;

  // operand reads
  assign w_rs1_e = r_entries[bus.rs1_rob_entry];
  assign w_rs2_e = r_entries[bus.rs2_rob_entry];

`ifdef ROB_CDB_BYPASS_EN
  logic w_rs1_hit;
  logic w_rs2_hit;
  assign w_rs1_hit     = bus.cdb_valid && (bus.cdb_rob_entry == bus.rs1_rob_entry);
  assign w_rs2_hit     = bus.cdb_valid && (bus.cdb_rob_entry == bus.rs2_rob_entry);
  assign bus.rs1_ready = w_rs1_hit || (w_rs1_e.valid && w_rs1_e.ready);
  assign bus.rs2_ready = w_rs2_hit || (w_rs2_e.valid && w_rs2_e.ready);
  assign bus.rs1_data  = w_rs1_hit ? bus.cdb_data : w_rs1_e.data;
  assign bus.rs2_data  = w_rs2_hit ? bus.cdb_data : w_rs2_e.data;
`else
  // A stale ready bit may survive a flush, so qualify with valid.
  assign bus.rs1_ready = w_rs1_e.valid && w_rs1_e.ready;
  assign bus.rs2_ready = w_rs2_e.valid && w_rs2_e.ready;
  assign bus.rs1_data  = w_rs1_e.data;
  assign bus.rs2_data  = w_rs2_e.data;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head <= '0;
      r_tail <= '0;
      for (int i = 0; i < ROB_LENGTH; i++) begin
        r_entries[i] <= '0;
      end
    end else if (w_flush) begin
      // The mispredicted entry's write still reaches the register file this
      // cycle; everything younger, plus same-cycle alloc/CDB, is dropped.
      r_head <= '0;
      r_tail <= '0;
      for (int i = 0; i < ROB_LENGTH; i++) begin
        r_entries[i].valid <= 1'b0;
      end
    end else begin
      if (w_alloc_fire) begin
        r_entries[w_tail_idx].valid      <= 1'b1;
        r_entries[w_tail_idx].ready      <= 1'b0;
        r_entries[w_tail_idx].mispredict <= 1'b0;
        r_entries[w_tail_idx].rd_addr    <= bus.alloc_rd_addr;
        r_tail                           <= r_tail + c_PTR_ONE;
      end
      // The allocating slot is invalid before this edge, so a broadcast can
      // never collide with the entry being allocated.
      if (bus.cdb_valid && r_entries[bus.cdb_rob_entry].valid) begin
        r_entries[bus.cdb_rob_entry].ready      <= 1'b1;
        r_entries[bus.cdb_rob_entry].data       <= bus.cdb_data;
        r_entries[bus.cdb_rob_entry].mispredict <= bus.cdb_mispredict;
      end
      if (w_commit) begin
        r_entries[w_head_idx].valid <= 1'b0;
        r_head                      <= r_head + c_PTR_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rob.sv
// ============================================================================
//  Module     : tb_rob
//  Description: Self-checking bench for rob. A queue-based model of the
//               in-flight instruction window is compared against the DUT on
//               every falling edge; directed scenarios add literal checks.
//  Config     : honours ROB_CDB_BYPASS_EN like the design.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rob;

  localparam int DW = 32;
  localparam int RL = 8;
  localparam int AW = 5;
  localparam int RW = $clog2(RL);

`ifdef ROB_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  rob_if #(.DATA_WIDTH(DW), .ROB_LENGTH(RL), .ADDR_WIDTH(AW)) bus ();

  rob #(.DATA_WIDTH(DW), .ROB_LENGTH(RL), .ADDR_WIDTH(AW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model: program-order window ----------------
  typedef struct {
    int          tag;
    int          rd;
    bit          rdy;
    bit          mp;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   tail_cnt = 0;

  function automatic bit m_we();
    return (q.size() > 0) && q[0].rdy;
  endfunction

  function automatic bit m_flush();
    return m_we() && q[0].mp;
  endfunction

  function automatic void m_rs(input int t, output bit r, output logic [31:0] d);
    r = 1'b0;
    d = '0;
    foreach (q[i]) begin
      if (q[i].tag == t && q[i].rdy) begin
        r = 1'b1;
        d = q[i].data;
      end
    end
    if (BYP && bus.cdb_valid && int'(bus.cdb_rob_entry) == t) begin
      r = 1'b1;
      d = bus.cdb_data;
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    bit   we;
    bit   fl;
    bit   ar;
    ent_t e;
    if (!rst) begin
      q.delete();
      tail_cnt = 0;
    end else begin
      we = m_we();
      fl = m_flush();
      ar = (q.size() < RL) && !fl;
      if (fl) begin
        q.delete();
        tail_cnt = 0;
      end else begin
        if (bus.cdb_valid) begin
          foreach (q[i]) begin
            if (q[i].tag == int'(bus.cdb_rob_entry)) begin
              q[i].rdy  = 1'b1;
              q[i].mp   = bus.cdb_mispredict;
              q[i].data = bus.cdb_data;
            end
          end
        end
        if (we) void'(q.pop_front());
        if (bus.alloc_valid && ar) begin
          e.tag  = tail_cnt % RL;
          e.rd   = int'(bus.alloc_rd_addr);
          e.rdy  = 1'b0;
          e.mp   = 1'b0;
          e.data = '0;
          q.push_back(e);
          tail_cnt++;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit          r;
    logic [31:0] d;
    chk("m_count", 32'(bus.count), q.size());
    chk("m_alloc_ready", 32'(bus.alloc_ready), 32'((q.size() < RL) && !m_flush()));
    chk("m_alloc_tag", 32'(bus.alloc_rob_entry), tail_cnt % RL);
    chk("m_regf_we", 32'(bus.regf_we), 32'(m_we()));
    chk("m_br_flush", 32'(bus.br_flush), 32'(m_flush()));
    if (m_we()) begin
      chk("m_commit_tag", 32'(bus.commit_rob_entry), q[0].tag);
      chk("m_rd_addr", 32'(bus.rd_addr), q[0].rd);
      chk("m_rd_data", bus.rd_data, q[0].data);
    end
    m_rs(int'(bus.rs1_rob_entry), r, d);
    chk("m_rs1_ready", 32'(bus.rs1_ready), 32'(r));
    if (r) chk("m_rs1_data", bus.rs1_data, d);
    m_rs(int'(bus.rs2_rob_entry), r, d);
    chk("m_rs2_ready", 32'(bus.rs2_ready), 32'(r));
    if (r) chk("m_rs2_data", bus.rs2_data, d);
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.alloc_valid    = 1'b0;
    bus.alloc_rd_addr  = '0;
    bus.cdb_valid      = 1'b0;
    bus.cdb_rob_entry  = '0;
    bus.cdb_data       = '0;
    bus.cdb_mispredict = 1'b0;
    bus.rs1_rob_entry  = '0;
    bus.rs2_rob_entry  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic alloc(input int rd);
    bus.alloc_valid   = 1'b1;
    bus.alloc_rd_addr = AW'(rd);
  endtask

  task automatic cdb(input int tag, input logic [31:0] data, input bit mp);
    bus.cdb_valid      = 1'b1;
    bus.cdb_rob_entry  = RW'(tag);
    bus.cdb_data       = data;
    bus.cdb_mispredict = mp;
  endtask

  initial begin
    idle();
    #2;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_alloc_ready", 32'(bus.alloc_ready), 1);
    chk("rst_alloc_tag", 32'(bus.alloc_rob_entry), 0);
    chk("rst_regf_we", 32'(bus.regf_we), 0);
    chk("rst_br_flush", 32'(bus.br_flush), 0);
    chk("rst_rs1_ready", 32'(bus.rs1_ready), 0);
    tick();
    rst = 1'b1;

    // fill 8 entries, tags 0..7, then a 9th request is refused
    for (int i = 0; i < RL; i++) begin
      alloc(i + 1);
      look();
      chk("fill_tag", 32'(bus.alloc_rob_entry), i);
      chk("fill_ready", 32'(bus.alloc_ready), 1);
      tick();
    end
    alloc(9);
    look();
    chk("full_alloc_ready", 32'(bus.alloc_ready), 0);
    chk("full_count", 32'(bus.count), 8);
    tick();
    idle();
    look();
    chk("full_count_hold", 32'(bus.count), 8);
    chk("full_tail_wrap", 32'(bus.alloc_rob_entry), 0);

    // out-of-order writeback, in-order commit
    cdb(2, 32'hAA, 1'b0);
    look();
    chk("ooo_no_commit", 32'(bus.regf_we), 0);
    tick();
    cdb(0, 32'h11, 1'b0);
    tick();
    idle();
    look();
    chk("c0_we", 32'(bus.regf_we), 1);
    chk("c0_tag", 32'(bus.commit_rob_entry), 0);
    chk("c0_rd", 32'(bus.rd_addr), 1);
    chk("c0_data", bus.rd_data, 32'h11);
    tick();
    look();
    chk("tag2_waits", 32'(bus.regf_we), 0);
    chk("c0_count", 32'(bus.count), 7);
    cdb(1, 32'h22, 1'b0);
    tick();
    idle();
    look();
    chk("c1_tag", 32'(bus.commit_rob_entry), 1);
    chk("c1_data", bus.rd_data, 32'h22);
    tick();
    look();
    chk("c2_tag", 32'(bus.commit_rob_entry), 2);
    chk("c2_rd", 32'(bus.rd_addr), 3);
    chk("c2_data", bus.rd_data, 32'hAA);
    tick();

    // clean restart
    rst = 1'b0;
    tick();
    rst = 1'b1;

    // full + commit + allocate in the same cycle
    for (int i = 0; i < RL; i++) begin
      alloc(i + 1);
      tick();
    end
    idle();
    cdb(0, 32'h10, 1'b0);
    tick();
    idle();
    alloc(20);
    look();
    chk("fc_we", 32'(bus.regf_we), 1);
    chk("fc_alloc_blocked", 32'(bus.alloc_ready), 0);
    chk("fc_count", 32'(bus.count), 8);
    tick();
    look();
    chk("fc_alloc_ok", 32'(bus.alloc_ready), 1);
    chk("fc_alloc_tag", 32'(bus.alloc_rob_entry), 0);
    chk("fc_count7", 32'(bus.count), 7);
    tick();
    idle();
    look();
    chk("fc_count8", 32'(bus.count), 8);

    // mispredict flush at head tag 1; same-cycle CDB/alloc dropped
    cdb(1, 32'h44, 1'b1);
    tick();
    idle();
    cdb(2, 32'h99, 1'b0);
    alloc(21);
    look();
    chk("fl_we", 32'(bus.regf_we), 1);
    chk("fl_flush", 32'(bus.br_flush), 1);
    chk("fl_tag", 32'(bus.commit_rob_entry), 1);
    chk("fl_data", bus.rd_data, 32'h44);
    chk("fl_alloc_ready", 32'(bus.alloc_ready), 0);
    tick();
    idle();
    look();
    chk("fl_count", 32'(bus.count), 0);
    chk("fl_alloc_tag", 32'(bus.alloc_rob_entry), 0);
    chk("fl_we_after", 32'(bus.regf_we), 0);

    // operand read during broadcast
    for (int i = 0; i < 4; i++) begin
      alloc(i + 1);
      tick();
    end
    idle();
    cdb(3, 32'h55, 1'b0);
    bus.rs1_rob_entry = 3'd3;
    look();
    chk("byp_rs1_ready", 32'(bus.rs1_ready), 32'(BYP));
    if (BYP) chk("byp_rs1_data", bus.rs1_data, 32'h55);
    tick();
    idle();
    bus.rs1_rob_entry = 3'd3;
    look();
    chk("rd_rs1_ready", 32'(bus.rs1_ready), 1);
    chk("rd_rs1_data", bus.rs1_data, 32'h55);
    chk("rd_no_commit", 32'(bus.regf_we), 0);
    chk("rd_count", 32'(bus.count), 4);

    // asynchronous reset with 4 entries in flight
    #2;
    rst = 1'b0;
    #1;
    chk("ar_count", 32'(bus.count), 0);
    chk("ar_alloc_ready", 32'(bus.alloc_ready), 1);
    chk("ar_rs1_ready", 32'(bus.rs1_ready), 0);
    chk("ar_regf_we", 32'(bus.regf_we), 0);
    tick();
    rst = 1'b1;
    idle();
    cdb(0, 32'h77, 1'b0);
    tick();
    idle();
    look();
    chk("ar_cdb_ignored", 32'(bus.rs2_ready), 0);
    chk("ar_cdb_no_we", 32'(bus.regf_we), 0);
    chk("ar_cdb_count", 32'(bus.count), 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog at %0t: actual=running expected=finished", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/rob.md
# rob

Reorder buffer for the Tomasulo RV32I core: a circular buffer of in-flight instructions that allocates tags at decode, captures results from the common data bus (CDB), and retires entries in program order into the architectural register file. It produces exactly the commit interface the register file consumes (`regf_we`, `rd_addr`, `rd_data`, `commit_rob_entry`, `br_flush`) and the allocation tag that decode writes into the register file's dependency table. It also serves operand reads for reservation stations whose sources are still in flight.

## Interface
- `DATA_WIDTH`, 32, result width
- `ROB_LENGTH`, 8, number of entries (power of two, ≥2)
- `ADDR_WIDTH`, 5, architectural register index width
- `ROB_WIDTH`, $clog2(ROB_LENGTH), tag width
- `clk` in 1: the single clock
- `rst` in 1: asynchronous, active-low reset
- `alloc_valid` in 1: decode requests an entry
- `alloc_rd_addr` in ADDR_WIDTH: destination register of the allocating instruction
- `alloc_ready` out 1: an entry can be allocated this cycle
- `alloc_rob_entry` out ROB_WIDTH: tag to be assigned (the current tail)
- `cdb_valid` in 1: result broadcast
- `cdb_rob_entry` in ROB_WIDTH: tag of the broadcast
- `cdb_data` in DATA_WIDTH: result value
- `cdb_mispredict` in 1: the broadcasting instruction is a mispredicted branch or jump
- `rs1_rob_entry`, `rs2_rob_entry` in ROB_WIDTH: source tags queried by dispatch
- `rs1_ready`, `rs2_ready` out 1: the queried entry holds its result
- `rs1_data`, `rs2_data` out DATA_WIDTH: the queried entry's result
- `regf_we` out 1: commit this cycle
- `rd_addr` out ADDR_WIDTH: committing destination register
- `rd_data` out DATA_WIDTH: committing value
- `commit_rob_entry` out ROB_WIDTH: committing tag
- `br_flush` out 1: the committing entry is mispredicted; flush all state
- `count` out ROB_WIDTH+1: occupied entries

## Operation
- **Pointers:** `head` and `tail` are ROB_WIDTH+1 bits; the MSB is the wrap bit.
  - Full when the indices are equal and the wrap bits differ.
  - Empty when the pointers are equal.
- **Per-entry state:** valid, ready, mispredict, rd_addr, data.
- **Allocation** fires when `alloc_valid && alloc_ready`.
  - `alloc_ready = !full && !br_flush`. Fullness comes from registered state, so a simultaneous commit does not free a slot in the same cycle.
  - On fire: the entry at the tail gets valid=1, ready=0, mispredict=0, rd_addr captured; the tail increments.
- **CDB writeback:** when `cdb_valid` is high and the target entry is valid, set ready=1 and capture data and mispredict. A broadcast to an invalid entry is ignored.
- **Commit:** whenever the head entry is valid and ready.
  - `regf_we=1`. `rd_addr`, `rd_data` and `commit_rob_entry=head` come from the head entry. The head then increments.
  - A commit with rd=0 still asserts `regf_we`; the register file discards it.
  - At most one commit per cycle.
- **Flush:** `br_flush = regf_we && head.mispredict`, asserted together with the commit write, so link values still reach the register file.
  - At that edge: every entry's valid clears, head=tail=0, and any same-cycle allocation or CDB write is dropped.
- **Operand read:** `rsN_ready`/`rsN_data` reflect the stored entry state (subject to the bypass in Configuration).
- **Count:** `count = tail - head` (modular, ROB_WIDTH+1 bits).

## Timing
- **Reset** (`rst` low, asynchronous):
  - head=tail=0, all entries invalid.
  - Outputs: `regf_we=0`, `br_flush=0`, `count=0`, `alloc_ready=1`, `alloc_rob_entry=0`, `rsN_ready=0`.
  - Reset asserted mid-operation discards all in-flight entries immediately.
- **Commit outputs** are combinational from registered state. A CDB write to the head entry at edge N makes that entry commit-visible during cycle N+1.
- **Allocate-to-commit latency:** at least 2 cycles.
- **Wrap-around:** tags repeat modulo ROB_LENGTH; only the wrap bit distinguishes full from empty.
- **Simultaneous events:**
  - Allocate, CDB write and commit to distinct entries in the same cycle all take effect.
  - Allocate into the slot being committed cannot occur, because full blocks it.

## Configuration
- `ROB_CDB_BYPASS_EN` defined:
  - If `cdb_valid` and `cdb_rob_entry == rsN_rob_entry` in the same cycle, `rsN_ready=1` and `rsN_data=cdb_data` combinationally.
- Undefined:
  - The operand ports show stored state only.
  - A result becomes readable one cycle after its broadcast.

## Structure
- Shared package `rv32i_types` holds:
  - `rob_entry_t`, a packed struct {valid, ready, mispredict, rd_addr, data}.
  - The ROB_LENGTH default constant.
- No sub-module: pointer logic, entry array and read muxes live in one module.

## Test plan
- Reset, allocate 8 entries (rd=1..8) -> tags 0..7 issued, `alloc_ready=0`, `count=8`; a 9th request is not accepted.
- CDB writes tag 2 (0xAA) then tag 0 (0x11) -> commit tag 0 (rd=1, data 0x11) only; tag 2 waits until tag 1 is written.
- Fill, commit one entry and allocate in the same cycle -> allocation rejected that cycle, accepted next cycle with tag 0 (wrap); `count` returns to 8.
- Tag 1 broadcasts with `cdb_mispredict=1` while tags 2..5 are valid -> tag 1 commits with `regf_we=1`, `br_flush=1`; next cycle `count=0`, `alloc_rob_entry=0`.
- Query `rs1_rob_entry=3` while tag 3 broadcasts 0x55 -> `rs1_ready=1`, `rs1_data=0x55` the same cycle with `ROB_CDB_BYPASS_EN` defined; otherwise the next cycle.
- Assert `rst` low asynchronously with 4 entries in flight -> outputs reach reset values without a clock edge; a CDB write to tag 0 after release is ignored.
